// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with sub-word read-modify-write
module load_store_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              I_clk,
  input  logic              I_rstn,
  input  logic              I_req,
  input  logic              I_we,
  input  logic [2:0]        I_funct3,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [31:0]       I_wdata,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_fault,
  output logic [31:0]       O_rdata,
  output logic [31:0]       O_mem_addr,
  output logic              O_mem_we,
  output logic [31:0]       O_mem_wdata,
  input  logic [31:0]       I_mem_rdata
);

  localparam int AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW, S_STORE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [2:0]     req_size;
  logic           req_fault;
  logic [AW1-1:0] req_end;
  logic [31:0]    addr32;

  // Classify the incoming request: access size and every reason to reject it
  always_comb begin
    req_size  = 3'd0;
    req_fault = 1'b0;
    addr32    = 32'(I_addr);
    case (I_funct3)
      3'b000, 3'b100: req_size = 3'd1;
      3'b001, 3'b101: req_size = 3'd2;
      3'b010:         req_size = 3'd4;
      default:        req_fault = 1'b1;
    endcase
    // Unsigned loads have no store counterpart
    if (I_we && I_funct3[2]) req_fault = 1'b1;
    if ((req_size == 3'd2) && I_addr[0]) req_fault = 1'b1;
    if ((req_size == 3'd4) && (I_addr[1:0] != 2'b00)) req_fault = 1'b1;
    // One extra bit so addresses near the top of the space cannot wrap past the check
    req_end = {1'b0, I_addr} + AW1'(req_size);
    if (req_end > AW1'(MEM_BYTES)) req_fault = 1'b1;
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  // Lane extraction for loads and lane insertion for sub-word stores
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = I_mem_rdata[7:0];
      2'd1:    ld_byte = I_mem_rdata[15:8];
      2'd2:    ld_byte = I_mem_rdata[23:16];
      default: ld_byte = I_mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = I_mem_rdata;
    endcase
    merged = I_mem_rdata;
    if (f3_q == 3'b000) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Next-state and registered-output computation for the access sequencer
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_req) begin
          f3_d    = I_funct3;
          lane_d  = I_addr[1:0];
          wdata_d = I_wdata[15:0];
          if (req_fault) begin
            // Rejected accesses never touch the memory port or the load result
            state_d = S_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            mem_addr_d = addr32 & ~32'h3;
            if (!I_we) begin
              state_d = S_LOAD;
            end else if (I_funct3 == 3'b010) begin
              state_d     = S_STORE;
              mem_we_d    = 1'b1;
              mem_wdata_d = I_wdata;
            end else begin
              state_d = S_RMW;
            end
          end
        end
      end
      S_LOAD: begin
        rdata_d = ld_val;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_RMW: begin
        mem_wdata_d = merged;
        mem_we_d    = 1'b1;
        state_d     = S_STORE;
      end
      S_STORE: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q     <= S_IDLE;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_fault     = fault_q;
  assign O_rdata     = rdata_q;
  assign O_mem_addr  = mem_addr_q;
  assign O_mem_we    = mem_we_q;
  assign O_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-array reference model
module tb_load_store_unit;

  logic        I_clk = 1'b0;
  logic        I_rstn = 1'b0;
  logic        I_req = 1'b0;
  logic        I_we = 1'b0;
  logic [2:0]  I_funct3 = 3'd0;
  logic [31:0] I_addr = 32'd0;
  logic [31:0] I_wdata = 32'd0;
  logic        O_busy, O_done, O_fault, O_mem_we;
  logic [31:0] O_rdata, O_mem_addr, O_mem_wdata, I_mem_rdata;

  always #5 I_clk = ~I_clk;

  load_store_unit #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .I_clk(I_clk), .I_rstn(I_rstn), .I_req(I_req), .I_we(I_we),
    .I_funct3(I_funct3), .I_addr(I_addr), .I_wdata(I_wdata),
    .O_busy(O_busy), .O_done(O_done), .O_fault(O_fault), .O_rdata(O_rdata),
    .O_mem_addr(O_mem_addr), .O_mem_we(O_mem_we), .O_mem_wdata(O_mem_wdata),
    .I_mem_rdata(I_mem_rdata)
  );

  // Attached data memory (word array) with a preload port used during reset
  logic [31:0] mem [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = 8'd0;
  logic [31:0] ld_val = 32'd0;
  always @(posedge I_clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (O_mem_we) mem[O_mem_addr[9:2]] <= O_mem_wdata;
  end
  assign I_mem_rdata = mem[O_mem_addr[9:2]];

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // Reference model state: plain byte array plus last load result
  byte unsigned ref_mem [0:1023];
  logic [31:0]  ref_rdata = 32'd0;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          issue;
    int          lat;
    int          wr_base;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  exp_t q[$];
  int   wr_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Expected outcome of one access, computed from the architectural rules
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int     sz;
    longint a;
    int     ia;
    logic [31:0] v;
    a  = longint'(addr);
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
    e.fault = (sz == 0) || (we && f3 >= 3'd4) || (sz == 2 && (a % 2) != 0) ||
              (sz == 4 && (a % 4) != 0) || (a + sz > 1024);
    e.nwr = 0; e.waddr = 32'd0; e.wword = 32'd0;
    if (e.fault) begin
      e.lat = 1;
    end else begin
      ia = int'(a);
      if (!we) begin
        e.lat = 2;
        if (sz == 1) v = (f3 == 3'd0) ? 32'($signed(ref_mem[ia])) : 32'(ref_mem[ia]);
        else if (sz == 2) v = (f3 == 3'd1) ? 32'($signed({ref_mem[ia+1], ref_mem[ia]}))
                                           : 32'({ref_mem[ia+1], ref_mem[ia]});
        else v = ref_word(ia);
        ref_rdata = v;
      end else begin
        e.lat = (sz == 4) ? 2 : 3;
        for (int k = 0; k < sz; k++) ref_mem[ia+k] = wd[8*k +: 8];
        e.nwr   = 1;
        e.waddr = 32'(ia - (ia % 4));
        e.wword = ref_word(ia - (ia % 4));
      end
    end
    e.rdata = ref_rdata;
  endtask

  // Monitor: checks write pulses and completions against the scoreboard queue
  always @(negedge I_clk) begin
    exp_t e;
    if (I_rstn) begin
      if (O_mem_we) begin
        wr_cnt++;
        if (q.size() == 0) chk("stray_write", 32'd1, 32'd0);
        else begin
          chk("write_addr", O_mem_addr, q[0].waddr);
          chk("write_data", O_mem_wdata, q[0].wword);
          chk("write_cycle", 32'(cyc - q[0].issue), 32'(q[0].lat - 1));
        end
      end
      if (O_done) begin
        if (q.size() == 0) chk("stray_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("fault", 32'(O_fault), 32'(e.fault));
          chk("rdata", O_rdata, e.rdata);
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("write_count", 32'(wr_cnt - e.wr_base), 32'(e.nwr));
          chk("busy_in_done", 32'(O_busy), 32'd1);
        end
      end
    end
  end

  // Issue one request (call just after a clock edge); keep holds I_req high afterwards
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit keep);
    exp_t e;
    bit   got;
    I_req = 1'b1; I_we = we; I_funct3 = f3; I_addr = addr; I_wdata = wd;
    model(we, f3, addr, wd, e);
    e.issue   = cyc;
    e.wr_base = wr_cnt;
    q.push_back(e);
    @(posedge I_clk);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge I_clk);
      if (O_done) begin got = 1; break; end
      // Unit is busy: these must be ignored and the latched request used
      I_we = 1'($urandom); I_funct3 = 3'($urandom); I_addr = $urandom; I_wdata = $urandom;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (q.size() > 0) void'(q.pop_front());
    end
    @(posedge I_clk);
    #1;
    if (!keep) I_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(O_busy), 32'd0);
    chk({tag, "_done"}, 32'(O_done), 32'd0);
    chk({tag, "_fault"}, 32'(O_fault), 32'd0);
    chk({tag, "_mem_we"}, 32'(O_mem_we), 32'd0);
    chk({tag, "_mem_addr"}, O_mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, O_mem_wdata, 32'd0);
    chk({tag, "_rdata"}, O_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] w, a, d;
    int saved_wr;
    // Preload memory and reference model while reset is held
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (i == 4) w = 32'h8899AABB;
      if (i == 8) w = 32'h11223344;
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = w[8*k +: 8];
      @(negedge I_clk);
      ld_en = 1'b1; ld_idx = 8'(i); ld_val = w;
    end
    @(negedge I_clk);
    ld_en = 1'b0;
    chk_all_zero("reset");
    I_rstn = 1'b1;
    #1;

    // Directed cases
    do_access(1'b0, 3'b000, 32'h11, 32'h0, 0);         // LB  -> FFFFFFAA
    do_access(1'b0, 3'b100, 32'h11, 32'h0, 0);         // LBU -> 000000AA
    do_access(1'b1, 3'b001, 32'h22, 32'hDEADBEEF, 0);  // SH  -> BEEF3344
    do_access(1'b0, 3'b010, 32'h20, 32'h0, 0);
    do_access(1'b0, 3'b010, 32'h3FC, 32'h0, 0);        // last word, in range
    do_access(1'b0, 3'b010, 32'h3FE, 32'h0, 0);        // misaligned word
    do_access(1'b0, 3'b001, 32'h3FF, 32'h0, 0);        // misaligned half at top
    do_access(1'b1, 3'b100, 32'h30, 32'h12345678, 0);  // store with unsigned code
    do_access(1'b0, 3'b011, 32'h30, 32'h0, 0);         // undefined size code
    do_access(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 0);   // would wrap the address space

    // Reset during the read-modify-write of a byte store
    I_req = 1'b1; I_we = 1'b1; I_funct3 = 3'b000; I_addr = 32'h25; I_wdata = 32'h5A;
    @(posedge I_clk);
    #1;
    saved_wr = wr_cnt;
    I_rstn = 1'b0;
    I_req  = 1'b0;
    #1;
    chk_all_zero("abort");
    ref_rdata = 32'd0;
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    chk("abort_no_write", 32'(wr_cnt), 32'(saved_wr));
    chk("abort_mem_word", mem[9], ref_word(32'h24));
    I_rstn = 1'b1;
    #1;
    do_access(1'b0, 3'b010, 32'h24, 32'h0, 0);

    // Back-to-back SW/LW with request held high
    for (int k = 0; k < 4; k++) begin
      do_access(1'b1, 3'b010, 32'h40, $urandom, 1);
      do_access(1'b0, 3'b010, 32'h40, 32'h0, (k != 3));
    end

    // Randomized mix, biased toward legal accesses
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'hFFFFFFF8 + $urandom_range(0, 7);
        1:       a = 32'($urandom_range(1016, 1040));
        default: a = 32'($urandom_range(0, 1023));
      endcase
      d = $urandom;
      do_access(1'($urandom), 3'($urandom_range(0, 7)), a, d, 1'($urandom));
    end
    I_req = 1'b0;

    repeat (4) @(posedge I_clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024: byte size of the attached data memory; accesses beyond it fault.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the CPU byte address.
REQ-003 SHALL have port I_clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port I_rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port I_req, input, 1: CPU access request, sampled only in IDLE.
REQ-006 SHALL have port I_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port I_funct3, input, 3: RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port I_addr, input, ADDR_W: byte address.
REQ-009 SHALL have port I_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port O_busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have port O_done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port O_fault, output, 1: valid with O_done; access rejected.
REQ-013 SHALL have port O_rdata, output, 32: load result, held until the next load completes.
REQ-014 SHALL have port O_mem_addr, output, 32: word-aligned memory address (low two bits 0).
REQ-015 SHALL have port O_mem_we, output, 1: memory write strobe.
REQ-016 SHALL have port O_mem_wdata, output, 32: full-word memory write data.
REQ-017 SHALL have port I_mem_rdata, input, 32: memory read word, combinational from O_mem_addr.

Function
REQ-018 SHALL implement states IDLE, LOAD, RMW, STORE, DONE.
REQ-019 IDLE with I_req=1 SHALL latch I_we, I_funct3, I_addr and I_wdata.
REQ-020 IDLE with I_req=1 SHALL then go to DONE with a fault if the access is faulting, else to LOAD (load), STORE (SW) or RMW (SB/SH).
REQ-021 An access SHALL fault on any of: funct3 not in {000,001,010,100,101}; store with funct3 100 or 101; H/HU with addr[0]=1; W with addr[1:0]!=0; addr+size > MEM_BYTES.
REQ-022 LOAD SHALL drive O_mem_addr={addr[31:2],2'b00} with O_mem_we=0.
REQ-023 LOAD SHALL then register the selected byte/half into O_rdata, sign-extended for B/H and zero-extended for BU/HU, and go to DONE.
REQ-024 RMW SHALL read the aligned word, capture it and go to STORE.
REQ-025 STORE SHALL assert O_mem_we=1 for exactly one cycle.
REQ-026 For SW, O_mem_wdata SHALL be I_wdata.
REQ-027 For SB/SH, O_mem_wdata SHALL be the captured word with the lane selected by addr[1:0] replaced by I_wdata[7:0] or [15:0], other lanes unchanged; STORE then goes to DONE.
REQ-028 DONE SHALL assert O_done=1 for one cycle, with O_fault=1 if faulting, then return to IDLE.
REQ-029 Latency from I_req in IDLE at cycle N to O_done SHALL be: fault N+1; load N+2; SW N+2; SB/SH N+3.
REQ-030 I_req SHALL be ignored while O_busy=1; back-to-back requests SHALL be accepted in the cycle after O_done.
REQ-031 A faulting access SHALL never assert O_mem_we and SHALL leave O_rdata unchanged.
REQ-032 O_mem_we SHALL be 0 in every state except STORE.
REQ-033 O_mem_addr SHALL hold its last value in IDLE and DONE.

Reset
REQ-034 I_rstn=0 SHALL immediately force state IDLE and O_busy, O_done, O_fault, O_mem_we, O_mem_addr, O_mem_wdata and O_rdata to 0.
REQ-035 Reset asserted mid-operation SHALL abort the access with no memory write and no O_done pulse.
REQ-036 The first request SHALL be accepted on the first rising edge after I_rstn deasserts.

Verification
REQ-037 Memory word 0x10 = 0x8899AABB; LB addr 0x11 -> O_done at N+2, O_rdata = 0xFFFFFFAA; LBU addr 0x11 -> 0x000000AA.
REQ-038 Memory word 0x20 = 0x11223344; SH addr 0x22 wdata 0xDEADBEEF -> one O_mem_we pulse at N+2 with O_mem_wdata = 0xBEEF3344, O_done at N+3.
REQ-039 LW addr 0x3FC with MEM_BYTES=1024 -> OK; LW addr 0x3FE -> O_fault; LH addr 0x3FF -> O_fault, O_done at N+1, no O_mem_we.
REQ-040 Store with funct3=100 -> O_fault=1, O_rdata unchanged, O_mem_we never asserted.
REQ-041 SB issued, I_rstn pulled low in RMW -> all outputs 0 and no write; after release, LW of the same word returns its original value.
REQ-042 I_req held high continuously with alternating SW/LW at addr 0x40 -> each accepted the cycle after the prior O_done; LW returns the last SW data.
